// File: rtl/fifo_write_ctrl_if.sv
// rtl/fifo_write_ctrl_if.sv - producer/RAM/read-domain signal bundle for the async FIFO write controller
// Optional drop_count member is present when FIFO_WR_DROP_CNT_EN is defined.
interface fifo_write_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic                  overflow_clr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
`ifdef FIFO_WR_DROP_CNT_EN
  logic [15:0]           drop_count;

  modport master (
    output wr_en, rd_ptr_gray, overflow_clr,
    input  mem_we, wr_addr, wr_ptr_gray, full, almost_full, level, overflow, drop_count
  );
  modport slave (
    input  wr_en, rd_ptr_gray, overflow_clr,
    output mem_we, wr_addr, wr_ptr_gray, full, almost_full, level, overflow, drop_count
  );
`else
  modport master (
    output wr_en, rd_ptr_gray, overflow_clr,
    input  mem_we, wr_addr, wr_ptr_gray, full, almost_full, level, overflow
  );
  modport slave (
    input  wr_en, rd_ptr_gray, overflow_clr,
    output mem_we, wr_addr, wr_ptr_gray, full, almost_full, level, overflow
  );
`endif
endinterface

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - write-side pointer, full/level and overflow control for a dual-clock FIFO
// Defining FIFO_WR_DROP_CNT_EN adds a saturating dropped-write counter (drop_count).
module fifo_write_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clock,
  input  logic            reset,
  fifo_write_ctrl_if.slave bus
);
  localparam int A = ADDR_WIDTH;
  localparam logic [A:0] AFULL_T = (A+1)'(AFULL_THRESH);

  logic [A:0] wr_bin;
  logic [A:0] wr_gray;
  logic [A:0] next_bin;
  logic [A:0] next_gray;
  logic [A:0] rd_sync [SYNC_STAGES];
  logic [A:0] rd_gray_s;
  logic [A:0] rd_bin_s;
  logic [A:0] level_next;
  logic [A:0] level_q;
  logic       full_q;
  logic       almost_full_q;
  logic       overflow_q;
  logic       mem_we;
  logic       drop;
  logic       full_next;

  assign mem_we    = bus.wr_en & ~full_q;
  assign drop      = bus.wr_en & full_q;
  assign next_bin  = wr_bin + {{A{1'b0}}, mem_we};
  assign next_gray = next_bin ^ (next_bin >> 1);
  assign rd_gray_s = rd_sync[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin_s = '0;
    for (int i = 0; i <= A; i++) begin
      rd_bin_s[i] = ^(rd_gray_s >> i);
    end
  end

  assign full_next  = (next_gray == {~rd_gray_s[A:A-1], rd_gray_s[A-2:0]});
  assign level_next = next_bin - rd_bin_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_bin        <= '0;
      wr_gray       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rd_sync[i] <= '0;
      end
    end else begin
      rd_sync[0] <= bus.rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rd_sync[i] <= rd_sync[i-1];
      end
      wr_bin        <= next_bin;
      wr_gray       <= next_gray;
      full_q        <= full_next;
      level_q       <= level_next;
      almost_full_q <= (level_next >= AFULL_T);
      // A new drop takes priority over a clear in the same cycle.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef FIFO_WR_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (bus.overflow_clr) begin
      drop_cnt <= {15'd0, drop};
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.drop_count = drop_cnt;
`endif

  assign bus.mem_we      = mem_we;
  assign bus.wr_addr     = wr_bin[A-1:0];
  assign bus.wr_ptr_gray = wr_gray;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
endmodule
